// File: rtl/lvds_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lvds_rx_pkg
//  Brief    : Shared constants and types for the LVDS I/Q receive path
//             (sync field values, I/Q field positions, lock state type).
//  Revision : 1.0  initial release
// ============================================================================
package lvds_rx_pkg;

  // Sync patterns carried in the two MSBs of each I and Q half-word
  localparam logic [1:0] SYNC_I = 2'b10;
  localparam logic [1:0] SYNC_Q = 2'b01;

  // 13-bit sample field positions inside the 32-bit link word
  localparam int I_MSB = 29;
  localparam int I_LSB = 17;
  localparam int Q_MSB = 13;
  localparam int Q_LSB = 1;

  typedef enum logic {
    LK_UNLOCKED = 1'b0,
    LK_LOCKED   = 1'b1
  } lock_state_t;

  // Sign-extend a 13-bit two's complement sample to 16 bits
  function automatic logic [15:0] sext13(input logic [12:0] v);
    return {{3{v[12]}}, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/iq_hold_buf.sv
`default_nettype none
// ============================================================================
//  Module   : iq_hold_buf
//  Brief    : One-entry hold register in front of the RX FIFO write port.
//             Parks a word while the FIFO is full, keeps ordering, and flags
//             a drop when a new word arrives with the hold slot occupied and
//             the FIFO still full.
//  Revision : 1.0  initial release
// ============================================================================
module iq_hold_buf
  import lvds_rx_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [DW-1:0] i_data,
  input  logic          i_valid,
  input  logic          i_full,
  output logic          o_push,
  output logic [DW-1:0] o_data,
  output logic          o_drop_evt
);

  logic          r_push;
  logic [DW-1:0] r_data;
  logic          r_hold_v;
  logic [DW-1:0] r_hold;

  // Decide push/hold at the edge; r_data only changes when a push is issued
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_push   <= 1'b0;
      r_data   <= '0;
      r_hold_v <= 1'b0;
      r_hold   <= '0;
    end else begin
      r_push <= 1'b0;
      if (r_hold_v) begin
        if (!i_full) begin
          // Drain the older held word first; a new word takes its place
          r_push   <= 1'b1;
          r_data   <= r_hold;
          r_hold_v <= i_valid;
          if (i_valid) r_hold <= i_data;
        end
      end else if (i_valid) begin
        if (!i_full) begin
          r_push <= 1'b1;
          r_data <= i_data;
        end else begin
          r_hold   <= i_data;
          r_hold_v <= 1'b1;
        end
      end
    end
  end

  // A word is lost only when both the FIFO and the hold slot are occupied
  assign o_drop_evt = r_hold_v & i_full & i_valid;
  assign o_push     = r_push;
  assign o_data     = r_data;

endmodule
`default_nettype wire

// File: rtl/lvds_rx_frame_check.sv
`default_nettype none
// ============================================================================
//  Module   : lvds_rx_frame_check
//  Brief    : Sync-field checker and lock tracker for deserialized LVDS I/Q
//             words. Unpacks samples, forwards locked words into the RX FIFO
//             through a hold buffer and keeps link statistics.
//  Revision : 1.0  initial release
// ============================================================================
module lvds_rx_frame_check
  import lvds_rx_pkg::*;
#(
  parameter int LOCK_WORDS  = 4,
  parameter int UNLOCK_ERRS = 3,
  parameter int SIGN_EXTEND = 1
) (
  input  logic        i_ddr_clk,
  input  logic        i_reset,
  input  logic        i_word_valid,
  input  logic [31:0] i_word,
  input  logic        i_stat_clear,
  input  logic        i_fifo_full,
  output logic        o_fifo_push,
  output logic [31:0] o_fifo_data,
  output logic        o_locked,
  output logic [15:0] o_err_count,
  output logic [15:0] o_drop_count,
  output logic [31:0] o_sample_count
);

  localparam logic [4:0] c_LOCK_WORDS  = 5'(LOCK_WORDS);
  localparam logic [4:0] c_UNLOCK_ERRS = 5'(UNLOCK_ERRS);

  lock_state_t r_state, w_state_nxt;
  logic [3:0]  r_good_cnt, w_good_cnt_nxt;
  logic [3:0]  r_bad_cnt, w_bad_cnt_nxt;
  logic        w_fwd;
  logic        w_good, w_eval_good, w_eval_bad;
  logic [31:0] w_unpacked;
  logic        r_fwd_valid;
  logic [31:0] r_fwd_data;
  logic        w_drop_evt;
  logic [15:0] r_err_count;
  logic [15:0] r_drop_count;
  logic [31:0] r_sample_count;

  assign w_good      = (i_word[31:30] == SYNC_I) && (i_word[15:14] == SYNC_Q);
  assign w_eval_good = i_word_valid & w_good;
  assign w_eval_bad  = i_word_valid & ~w_good;

  generate
    if (SIGN_EXTEND != 0) begin : g_sext
      // Control bits are not carried in the sign-extended sample format
      logic w_unused_ctrl;
      assign w_unused_ctrl = i_word[16] ^ i_word[0];
      assign w_unpacked = {sext13(i_word[I_MSB:I_LSB]), sext13(i_word[Q_MSB:Q_LSB])};
    end else begin : g_raw
      assign w_unpacked = i_word;
    end
  endgenerate

  // Lock state and run-length counters
  always_ff @(posedge i_ddr_clk) begin
    if (i_reset) begin
      r_state    <= LK_UNLOCKED;
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_good_cnt <= w_good_cnt_nxt;
      r_bad_cnt  <= w_bad_cnt_nxt;
    end
  end

  // Lock hysteresis and forward decision for the word on the input this cycle
  always_comb begin
    w_state_nxt    = r_state;
    w_good_cnt_nxt = r_good_cnt;
    w_bad_cnt_nxt  = r_bad_cnt;
    w_fwd          = 1'b0;
    case (r_state)
      LK_UNLOCKED: begin
        if (w_eval_good) begin
          if ({1'b0, r_good_cnt} + 5'd1 == c_LOCK_WORDS) begin
            // The word that completes lock is itself forwarded
            w_state_nxt    = LK_LOCKED;
            w_good_cnt_nxt = '0;
            w_fwd          = 1'b1;
          end else begin
            w_good_cnt_nxt = r_good_cnt + 4'd1;
          end
        end else if (w_eval_bad) begin
          w_good_cnt_nxt = '0;
        end
      end
      LK_LOCKED: begin
        if (w_eval_good) begin
          w_bad_cnt_nxt = '0;
          w_fwd         = 1'b1;
        end else if (w_eval_bad) begin
          if ({1'b0, r_bad_cnt} + 5'd1 == c_UNLOCK_ERRS) begin
            w_state_nxt   = LK_UNLOCKED;
            w_bad_cnt_nxt = '0;
          end else begin
            w_bad_cnt_nxt = r_bad_cnt + 4'd1;
          end
        end
      end
      default: begin
        w_state_nxt    = LK_UNLOCKED;
        w_good_cnt_nxt = '0;
        w_bad_cnt_nxt  = '0;
      end
    endcase
  end

  // One pipeline stage between acceptance and the hold buffer
  always_ff @(posedge i_ddr_clk) begin
    if (i_reset) begin
      r_fwd_valid <= 1'b0;
      r_fwd_data  <= '0;
    end else begin
      r_fwd_valid <= w_fwd;
      if (w_fwd) r_fwd_data <= w_unpacked;
    end
  end

  iq_hold_buf #(
    .DW(32)
  ) u_hold (
    .i_clk      (i_ddr_clk),
    .i_reset    (i_reset),
    .i_data     (r_fwd_data),
    .i_valid    (r_fwd_valid),
    .i_full     (i_fifo_full),
    .o_push     (o_fifo_push),
    .o_data     (o_fifo_data),
    .o_drop_evt (w_drop_evt)
  );

  // Statistics: clear beats any same-cycle increment; err/drop saturate
  always_ff @(posedge i_ddr_clk) begin
    if (i_reset || i_stat_clear) begin
      r_err_count    <= '0;
      r_drop_count   <= '0;
      r_sample_count <= '0;
    end else begin
      if (w_eval_bad && (r_err_count != 16'hFFFF)) r_err_count <= r_err_count + 16'd1;
      if (w_drop_evt && (r_drop_count != 16'hFFFF)) r_drop_count <= r_drop_count + 16'd1;
      if (o_fifo_push) r_sample_count <= r_sample_count + 32'd1;
    end
  end

  assign o_locked       = (r_state == LK_LOCKED);
  assign o_err_count    = r_err_count;
  assign o_drop_count   = r_drop_count;
  assign o_sample_count = r_sample_count;

endmodule
`default_nettype wire
